iob_csr_sub: RTL
================

IOB_CSR_SUB -- requirements
Module: iob_csr_sub

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, IOb native byte-address width; address bits [4:2] select one of 8 words.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, range 0..15, wait states inserted before ready_o.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port arst_i  input  1  reset; synchronous, active-high (one clock; reset is synchronous and active-high).
REQ-006 SHALL have port cke_i  input  1  clock enable; all state holds when 0.
REQ-007 SHALL have port iob_valid_i  input  1  request valid; manager holds it and addr/wdata/wstrb stable until ready_o.
REQ-008 SHALL have port iob_addr_i  input  ADDR_W  byte address.
REQ-009 SHALL have port iob_wdata_i  input  32  write data, byte-lane aligned.
REQ-010 SHALL have port iob_wstrb_i  input  4  byte strobes; 0 = read, nonzero = write.
REQ-011 SHALL have port iob_ready_o  output  1  request accepted this cycle.
REQ-012 SHALL have port iob_rvalid_o  output  1  read data valid, one-cycle pulse.
REQ-013 SHALL have port iob_rdata_o  output  32  read data.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-015 SHALL compute iob_ready_o = (IDLE and WAIT_CYCLES==0 and iob_valid_i) or ACK.
REQ-016 SHALL, in IDLE with iob_valid_i=1 and WAIT_CYCLES>0, load wait counter with WAIT_CYCLES-1 and go to WAIT.
REQ-017 SHALL, in WAIT, go to ACK when counter==0, else decrement; if iob_valid_i drops, return to IDLE without side effects.
REQ-018 SHALL, in ACK, accept the request and return to IDLE next cycle; first ready_o thus occurs WAIT_CYCLES+1 cycles after valid first sampled (0 wait: same cycle).
REQ-019 SHALL perform a write in the acceptance cycle, updating only lanes with wstrb bit set.
REQ-020 SHALL assert iob_rvalid_o for exactly one cycle, the cycle after a read is accepted, and hold iob_rdata_o until the next rvalid.
REQ-021 SHALL map word 0 CTRL (RW, reset 0; bit0 = counter enable), word 1 SCRATCH (RW, reset 0), word 2 COUNT (RO), word 3 STATUS (RO except W1C bit16).
REQ-022 SHALL increment COUNT by 1 every cke_i cycle with CTRL[0]=1, wrapping 0xFFFFFFFF->0; writes to COUNT ignored.
REQ-023 SHALL have STATUS[15:0] count accepted writes to any address, saturating at 0xFFFF; STATUS[31:17]=0.
REQ-024 SHALL set sticky STATUS[16] on any accepted access to words 4..7; a write to STATUS with wstrb[2]=1 and wdata[16]=1 clears it.
REQ-025 SHALL, for words 4..7, ack normally, ignore writes, return 0 on read.
REQ-026 SHALL, when CTRL write changes bit0, apply new enable from the next cycle; COUNT uses old enable in the write cycle.
REQ-027 SHALL give set priority over W1C clear when both occur in one access (unmapped W1C impossible; same-cycle only via counter of later access).
REQ-028 SHALL freeze FSM, counters, registers and rvalid when cke_i=0; an rvalid pending stays pending.

Reset
REQ-029 SHALL, on arst_i=1 at a clock edge (regardless of cke_i), set FSM IDLE, CTRL/SCRATCH/COUNT/STATUS=0, iob_rvalid_o=0, iob_rdata_o=0, iob_ready_o=0.
REQ-030 SHALL abort any in-flight request on reset; no write commits and no rvalid issues for it.

Verification
REQ-031 SHALL cover: write 0xA5A5A5A5 to 0x04, wstrb=0xF, WAIT_CYCLES=2 -> ready_o on 3rd cycle after valid; read 0x04 -> rvalid next cycle, rdata 0xA5A5A5A5.
REQ-032 SHALL cover: SCRATCH=0x11223344, write 0x0000BB00 wstrb=0x2 -> read 0x1122BB44.
REQ-033 SHALL cover: write CTRL=1, wait 10 cycles, write CTRL=0, read COUNT -> exactly cycles enabled; force COUNT=0xFFFFFFFF via hierarchy, enable 1 cycle -> 0.
REQ-034 SHALL cover: read 0x10 -> rdata 0, STATUS[16]=1; write STATUS 0x00010000 wstrb=0x4 -> STATUS[16]=0, STATUS[15:0] incremented by 1.
REQ-035 SHALL cover: assert arst_i during WAIT of a write to SCRATCH -> SCRATCH stays 0, no ready_o, no rvalid; cke_i=0 for 5 cycles mid-WAIT -> ready latency extended by 5.

Source files
------------

// File: rtl/iob_csr_sub.sv
// rtl/iob_csr_sub.sv - IOb native CSR subordinate with wait states, free-running counter and status
module iob_csr_sub #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o
);

    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  wcnt, wcnt_nx;

    logic [31:0] ctrl;
    logic [31:0] scratch;
    logic [31:0] count;
    logic [15:0] status_cnt;
    logic        status_err;

    logic        ready_raw;
    logic        accept;
    logic        wr_acc;
    logic        rd_acc;
    logic [2:0]  word;
    logic        unmapped;
    logic [31:0] wmask;
    logic        err_clr;
    logic [31:0] rd_word;
    logic        unused_addr;

    assign unused_addr = ^iob_addr_i;

    assign word     = iob_addr_i[4:2];
    assign unmapped = word[2];
    assign wmask    = {{8{iob_wstrb_i[3]}}, {8{iob_wstrb_i[2]}},
                       {8{iob_wstrb_i[1]}}, {8{iob_wstrb_i[0]}}};

    // Ready is suppressed while frozen or in reset so a request is never seen as
    // accepted unless its side effects actually commit on this edge.
    assign ready_raw   = ((state == ST_IDLE) && NO_WAIT && iob_valid_i) || (state == ST_ACK);
    assign iob_ready_o = ready_raw && cke_i && !arst_i;
    assign accept      = iob_ready_o && iob_valid_i;
    assign wr_acc      = accept && (iob_wstrb_i != '0);
    assign rd_acc      = accept && (iob_wstrb_i == '0);
    assign err_clr     = wr_acc && (word == 3'd3) && iob_wstrb_i[2] && iob_wdata_i[16];

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state <= ST_IDLE;
            wcnt  <= 4'd0;
        end else if (cke_i) begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            ST_IDLE: begin
                if (iob_valid_i && !NO_WAIT) begin
                    state_nx = ST_WAIT;
                    wcnt_nx  = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (!iob_valid_i) begin
                    state_nx = ST_IDLE;
                end else if (wcnt == 4'd0) begin
                    state_nx = ST_ACK;
                end else begin
                    wcnt_nx = wcnt - 4'd1;
                end
            end
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_word = 32'd0;
        case (word)
            3'd0:    rd_word = ctrl;
            3'd1:    rd_word = scratch;
            3'd2:    rd_word = count;
            3'd3:    rd_word = {15'd0, status_err, status_cnt};
            default: rd_word = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            ctrl         <= 32'd0;
            scratch      <= 32'd0;
            count        <= 32'd0;
            status_cnt   <= 16'd0;
            status_err   <= 1'b0;
            iob_rvalid_o <= 1'b0;
            iob_rdata_o  <= '0;
        end else if (cke_i) begin
            // COUNT sees the enable as registered before this edge's CTRL write.
            if (ctrl[0]) begin
                count <= count + 32'd1;
            end
            if (wr_acc && (word == 3'd0)) begin
                ctrl <= (ctrl & ~wmask) | (iob_wdata_i[31:0] & wmask);
            end
            if (wr_acc && (word == 3'd1)) begin
                scratch <= (scratch & ~wmask) | (iob_wdata_i[31:0] & wmask);
            end
            if (wr_acc && (status_cnt != 16'hFFFF)) begin
                status_cnt <= status_cnt + 16'd1;
            end
            status_err   <= (accept && unmapped) || (status_err && !err_clr);
            iob_rvalid_o <= rd_acc;
            if (rd_acc) begin
                iob_rdata_o <= rd_word;
            end
        end
    end

endmodule
